mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_W, default 32, width of address and data words.
REQ-002 Parameter TIMEOUT, default 64, number of granted cycles without ACCESS before the timeout flag sets.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 iREN  in  1  icache read request.
REQ-006 iaddr  in  WORD_W  icache address.
REQ-007 iwait  out  1  icache stall; low only in the icache completion cycle.
REQ-008 iload  out  WORD_W  icache read data.
REQ-009 dREN  in  1  dcache read request.
REQ-010 dWEN  in  1  dcache write request.
REQ-011 daddr  in  WORD_W  dcache address.
REQ-012 dstore  in  WORD_W  dcache write data.
REQ-013 dwait  out  1  dcache stall; low only in the dcache completion cycle.
REQ-014 dload  out  WORD_W  dcache read data.
REQ-015 ramREN  out  1  RAM read strobe.
REQ-016 ramWEN  out  1  RAM write strobe.
REQ-017 ramaddr  out  WORD_W  RAM address.
REQ-018 ramstore  out  WORD_W  RAM write data.
REQ-019 ramload  in  WORD_W  RAM read data.
REQ-020 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3 (ramstate_t).
REQ-021 arb_timeout  out  1  sticky timeout status.

Function
REQ-022 FSM states IDLE, IGRANT, DGRANT; state register only, RAM outputs decoded combinationally from state.
REQ-023 IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0; next state DGRANT if (dREN|dWEN), else IGRANT if iREN, else IDLE (fixed dcache priority).
REQ-024 IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-025 DGRANT: ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted), ramaddr=daddr, ramstore=dstore.
REQ-026 Completion: iwait=~(state==IGRANT && ramstate==ACCESS); dwait=~(state==DGRANT && ramstate==ACCESS).
REQ-027 On completion, next state is IDLE; one IDLE cycle always separates two grants.
REQ-028 Minimum latency: request asserted in cycle N (state IDLE), grant in N+1, wait low in N+1 if ramstate==ACCESS.
REQ-029 FREE, BUSY or ERROR while granted: hold grant and RAM strobes, wait stays high (ERROR is retried by holding).
REQ-030 Request withdrawn while granted (IGRANT with iREN=0, or DGRANT with dREN=dWEN=0): return to IDLE next cycle, no completion.
REQ-031 iload and dload equal ramload at all times; data is valid only in the requester's completion cycle.
REQ-032 Grant counter clears on entry to a grant state and increments each granted cycle without ACCESS; it saturates at TIMEOUT.
REQ-033 arb_timeout sets when the counter reaches TIMEOUT and stays set until RST; the grant is not released.
REQ-034 A new request arriving during another requester's grant waits; it is arbitrated in the next IDLE cycle.

Reset
REQ-035 RST high at a rising edge forces state=IDLE, counter=0, arb_timeout=0 and round-robin pointer=icache, including mid-transaction.
REQ-036 During and after reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.

Configuration
REQ-037 Macro ARB_RR_EN: when defined, IDLE arbitration with both requesters pending grants the requester not served last, using a 1-bit pointer updated on each completion.
REQ-038 Without ARB_RR_EN: fixed dcache priority per REQ-023; no pointer register.

Verification
REQ-039 Icache read: iREN=1, iaddr=0x100, ramstate=ACCESS one cycle after grant, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100; iwait low one cycle with iload=0xDEADBEEF; next state IDLE.
REQ-040 Contention without ARB_RR_EN: iREN=1 and dWEN=1 (daddr=0x200, dstore=0x12345678) together -> DGRANT first with ramWEN=1; icache is granted only after the IDLE cycle.
REQ-041 Contention with ARB_RR_EN, both requesters continuously pending -> grants alternate D, I, D, I with one IDLE cycle between each.
REQ-042 Timeout: DGRANT held with ramstate=BUSY for 64 cycles -> arb_timeout=1 and stays 1; DGRANT persists; ACCESS then completes the access normally.
REQ-043 Withdraw and reset: iREN dropped while ramstate=BUSY -> IDLE next cycle with iwait never low; RST pulsed during DGRANT -> outputs per REQ-036 next cycle.
REQ-044 dREN=dWEN=1 -> ramWEN=1, ramREN=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the icache, dcache and RAM sides of the memory
// arbiter into one interface.
//   slave  modport - the arbiter: takes cache requests and RAM status/data,
//                    drives cache stalls/data, RAM strobes and timeout flag.
//   master modport - the environment (caches + RAM model) driving the arbiter.
// ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
interface mem_arbiter_if #(
    parameter int WORD_W = 32
);
    // icache side
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    // dcache side
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    // RAM side
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;
    // status
    logic              arb_timeout;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore, arb_timeout
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore, arb_timeout
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between an icache (read only) and a
// dcache (read/write). One requester is granted at a time; a grant ends on
// a RAM ACCESS cycle (completion) or when the request is withdrawn, and an
// IDLE cycle always separates two grants. A sticky timeout flag reports a
// grant that has waited TIMEOUT cycles without ACCESS; the grant is kept.
//
// Ports:
//   CLK  - clock, all state updates on rising edge
//   RST  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave (cache requests/stalls/data, RAM
//          strobes/address/data/status, arb_timeout)
//
// Parameters:
//   WORD_W  - address/data width
//   TIMEOUT - granted cycles without ACCESS before arb_timeout sets
//
// Build option:
//   ARB_RR_EN - when defined, simultaneous requests in IDLE go to the
//               requester not served last (1-bit pointer, reset = icache).
//               When undefined, the dcache always wins.
//
// state  | meaning
// IDLE   | no grant, RAM strobes low, arbitrate pending requests
// IGRANT | icache owns the RAM (read)
// DGRANT | dcache owns the RAM (write wins over read)
module mem_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam int         CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  grant_cnt;
    logic              timeout_q;

    logic              access;
    logic              dreq;
    logic              pick_d;

    logic              ram_ren;
    logic              ram_wen;
    logic [WORD_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_store;
    logic              i_wait;
    logic              d_wait;

    assign access = (bus.ramstate == RAM_ACCESS);
    assign dreq   = bus.dREN | bus.dWEN;

`ifdef ARB_RR_EN
    // last_d: 1 when the dcache had the most recent completion.
    logic last_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_d <= 1'b0;
        end else if (access && state == IGRANT) begin
            last_d <= 1'b0;
        end else if (access && state == DGRANT) begin
            last_d <= 1'b1;
        end
    end

    // On contention, the dcache wins only if the icache was served last.
    assign pick_d = dreq & (~bus.iREN | ~last_d);
`else
    assign pick_d = dreq;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (pick_d) begin
                    state_next = DGRANT;
                end else if (bus.iREN) begin
                    state_next = IGRANT;
                end else begin
                    state_next = IDLE;
                end
            end
            IGRANT: begin
                if (access || !bus.iREN) begin
                    state_next = IDLE;
                end
            end
            DGRANT: begin
                if (access || !dreq) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        i_wait    = 1'b1;
        d_wait    = 1'b1;
        unique case (state)
            IGRANT: begin
                ram_ren  = 1'b1;
                ram_addr = bus.iaddr;
                i_wait   = ~access;
            end
            DGRANT: begin
                ram_wen   = bus.dWEN;
                ram_ren   = bus.dREN & ~bus.dWEN;
                ram_addr  = bus.daddr;
                ram_store = bus.dstore;
                d_wait    = ~access;
            end
            default: begin
                ram_ren = 1'b0;
            end
        endcase
    end

    // The counter is cleared while IDLE, so every grant starts from zero.
    // The flag is set on the same edge the counter reaches TIMEOUT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (state == IDLE) begin
            grant_cnt <= '0;
        end else if (!access && grant_cnt != CNT_MAX) begin
            grant_cnt <= grant_cnt + 1'b1;
            if (grant_cnt == CNT_LAST) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.ramREN      = ram_ren;
    assign bus.ramWEN      = ram_wen;
    assign bus.ramaddr     = ram_addr;
    assign bus.ramstore    = ram_store;
    assign bus.iwait       = i_wait;
    assign bus.dwait       = d_wait;
    assign bus.iload       = bus.ramload;
    assign bus.dload       = bus.ramload;
    assign bus.arb_timeout = timeout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int TO = 64;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int OW = 4 * W + 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.WORD_W(W)) bus ();
    mem_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache),
    // stall cycles seen in this grant, sticky timeout, last served requester.
    int m_own  = 0;
    int m_cnt  = 0;
    bit m_tmo  = 1'b0;
    int m_last = 1;

    function automatic logic [OW-1:0] exp_out();
        logic ren, wen, iw, dw;
        logic [W-1:0] a, s;
        bit acc;
        acc = (bus.ramstate == 2'd2);
        ren = 1'b0; wen = 1'b0; a = '0; s = '0; iw = 1'b1; dw = 1'b1;
        if (m_own == 1) begin
            ren = 1'b1; a = bus.iaddr; iw = !acc;
        end else if (m_own == 2) begin
            wen = bus.dWEN; ren = bus.dREN && !bus.dWEN;
            a = bus.daddr; s = bus.dstore; dw = !acc;
        end
        return {ren, wen, a, s, iw, dw, m_tmo, bus.ramload, bus.ramload};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iwait,
                bus.dwait, bus.arb_timeout, bus.iload, bus.dload};
    endfunction

    // Advance one clock and apply the arbitration rules to the model.
    task automatic tick();
        bit acc, dq;
        int nxt;
        @(posedge CLK);
        acc = (bus.ramstate == 2'd2);
        dq  = bus.dREN || bus.dWEN;
        if (RST) begin
            m_own = 0; m_cnt = 0; m_tmo = 1'b0; m_last = 1;
        end else if (m_own == 0) begin
            nxt = 0;
            if (dq && bus.iREN) nxt = (RR && m_last == 2) ? 1 : 2;
            else if (dq)        nxt = 2;
            else if (bus.iREN)  nxt = 1;
            m_cnt = 0;
            m_own = nxt;
        end else if (acc) begin
            m_last = m_own;
            m_own  = 0;
        end else begin
            if (m_cnt < TO) m_cnt++;
            if (m_cnt == TO) m_tmo = 1'b1;
            if ((m_own == 1 && !bus.iREN) || (m_own == 2 && !dq)) m_own = 0;
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = 2'd0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.iREN = 1'($urandom); bus.dREN = 1'($urandom); bus.dWEN = 1'($urandom);
            bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
            bus.ramload = $urandom; bus.ramstate = 2'($urandom);
            tick();
            #1; checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL reset c%0d got %h expected %h", c, obs(), exp_out());
            end
        end
        RST = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_icache_read();
        logic [1:0] st [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        bit         rq [4] = '{1, 1, 1, 0};
        for (int c = 0; c < 4; c++) begin
            bus.iREN = rq[c]; bus.iaddr = 32'h100; bus.ramstate = st[c];
            bus.ramload = (c == 2) ? 32'hDEADBEEF : $urandom;
            #1; checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL icache_read c%0d got %h expected %h", c, obs(), exp_out());
            end
            if (c == 2) begin
                checks++;
                if (bus.iwait !== 1'b0 || bus.iload !== 32'hDEADBEEF ||
                    bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100) begin
                    errors++;
                    $display("FAIL icache_done got iwait=%b iload=%h ren=%b addr=%h expected 0 deadbeef 1 100",
                             bus.iwait, bus.iload, bus.ramREN, bus.ramaddr);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        idle_inputs();
        bus.daddr = 32'h200; bus.dstore = 32'h12345678; bus.iaddr = 32'h300;
        bus.ramstate = 2'd2;
        for (int c = 0; c < 5; c++) begin
            bus.iREN = (c < 4); bus.dWEN = (c < 2);
            #1; checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL contention c%0d got %h expected %h", c, obs(), exp_out());
            end
            if (c == 1) begin
                checks++;
                if (bus.ramWEN !== 1'b1 || bus.dwait !== 1'b0 || bus.ramstore !== 32'h12345678) begin
                    errors++;
                    $display("FAIL contention_dfirst got wen=%b dwait=%b store=%h expected 1 0 12345678",
                             bus.ramWEN, bus.dwait, bus.ramstore);
                end
            end
            if (c == 2) begin
                checks++;
                if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
                    errors++;
                    $display("FAIL contention_gap got ren=%b iwait=%b expected 0 1", bus.ramREN, bus.iwait);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.iwait !== 1'b0 || bus.ramaddr !== 32'h300) begin
                    errors++;
                    $display("FAIL contention_ithen got iwait=%b addr=%h expected 0 300", bus.iwait, bus.ramaddr);
                end
            end
            tick();
        end
    endtask

    task automatic test_both_rw();
        idle_inputs();
        bus.daddr = $urandom; bus.dstore = $urandom; bus.ramstate = 2'd1;
        for (int c = 0; c < 4; c++) begin
            bus.dREN = (c < 3); bus.dWEN = (c < 3);
            #1; checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL both_rw c%0d got %h expected %h", c, obs(), exp_out());
            end
            if (c == 1) begin
                checks++;
                if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin
                    errors++;
                    $display("FAIL both_rw_strobe got wen=%b ren=%b expected 1 0", bus.ramWEN, bus.ramREN);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int seq[$];
        idle_inputs();
        RST = 1'b1; tick(); RST = 1'b0;
        bus.iREN = 1; bus.dREN = 1; bus.ramstate = 2'd2;
        for (int c = 0; c < 8; c++) begin
            bus.iaddr = $urandom; bus.daddr = $urandom; bus.ramload = $urandom;
            #1; checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL round_robin c%0d got %h expected %h", c, obs(), exp_out());
            end
            if (bus.dwait === 1'b0) seq.push_back(2);
            if (bus.iwait === 1'b0) seq.push_back(1);
            tick();
        end
        idle_inputs();
        checks++;
        if (seq.size() != 4) begin
            errors++;
            $display("FAIL rr_count got %0d grants expected 4", seq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (seq[k] != ((RR && k % 2 == 1) ? 1 : 2)) begin
                    errors++;
                    $display("FAIL rr_order k%0d got %0d expected %0d", k, seq[k], (RR && k % 2 == 1) ? 1 : 2);
                end
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        int g = 0;
        idle_inputs();
        RST = 1'b1; tick(); RST = 1'b0;
        bus.dREN = 1; bus.daddr = $urandom; bus.ramstate = 2'd1;
        for (int c = 0; c < 74; c++) begin
            if (c == 71) bus.ramstate = 2'd2;
            if (c == 72) begin bus.dREN = 0; bus.ramstate = 2'd0; end
            #1; checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL timeout c%0d got %h expected %h", c, obs(), exp_out());
            end
            if (c >= 1 && c <= 70) begin
                checks++;
                if (bus.arb_timeout !== (g >= TO) || bus.ramREN !== 1'b1 || bus.dwait !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_flag stall%0d got tmo=%b ren=%b dwait=%b expected %b 1 1",
                             g, bus.arb_timeout, bus.ramREN, bus.dwait, g >= TO);
                end
                g++;
            end
            if (c == 71) begin
                checks++;
                if (bus.dwait !== 1'b0 || bus.arb_timeout !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_done got dwait=%b tmo=%b expected 0 1", bus.dwait, bus.arb_timeout);
                end
            end
            tick();
        end
    endtask

    task automatic test_withdraw();
        bit saw_low = 1'b0;
        idle_inputs();
        bus.iaddr = $urandom; bus.ramstate = 2'd1;
        for (int c = 0; c < 5; c++) begin
            bus.iREN = (c < 3);
            #1; checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL withdraw c%0d got %h expected %h", c, obs(), exp_out());
            end
            if (bus.iwait !== 1'b1) saw_low = 1'b1;
            if (c == 4) begin
                checks++;
                if (bus.ramREN !== 1'b0 || saw_low) begin
                    errors++;
                    $display("FAIL withdraw_idle got ren=%b iwait_low_seen=%b expected 0 0", bus.ramREN, saw_low);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.dWEN = 1; bus.daddr = $urandom | 1; bus.dstore = $urandom; bus.ramstate = 2'd1;
        for (int c = 0; c < 5; c++) begin
            RST = (c == 2);
            #1; checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL reset_mid c%0d got %h expected %h", c, obs(), exp_out());
            end
            if (c == 3) begin
                checks++;
                if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0 || bus.ramaddr !== '0 ||
                    bus.ramstore !== '0 || bus.iwait !== 1'b1 || bus.dwait !== 1'b1 ||
                    bus.arb_timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_idle got wen=%b ren=%b addr=%h store=%h iw=%b dw=%b tmo=%b expected all idle",
                             bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.iwait, bus.dwait, bus.arb_timeout);
                end
            end
            tick();
        end
        RST = 1'b0;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.iREN = 1'($urandom);
            if ($urandom_range(0, 3) == 0) bus.dREN = 1'($urandom);
            if ($urandom_range(0, 3) == 0) bus.dWEN = 1'($urandom);
            bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
            bus.ramload = $urandom;
            bus.ramstate = ($urandom_range(0, 15) == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            RST = ($urandom_range(0, 299) == 0);
            #1; checks++;
            if (obs() !== exp_out()) begin
                errors++;
                $display("FAIL random c%0d got %h expected %h", c, obs(), exp_out());
            end
            tick();
        end
        RST = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge CLK);
        test_reset();
        test_icache_read();
        test_contention();
        test_both_rw();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
